// File: rtl/if_id_register_if.sv
// Signal bundle between the IF/ID pipeline register and its neighbours:
// fetch inputs, decode outputs, ID/EX hazard inputs and debug counters.
`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif

interface if_id_register_if #(
    parameter int WORDLENGTH = `WORDLENGTH,
    parameter int CNT_W      = 16
);
    logic [WORDLENGTH-1:0] instruction_in;
    logic [WORDLENGTH-1:0] PC_plus4_in;
    logic [1:0]            PC_src;
    logic                  idex_mem_read;
    logic [4:0]            idex_rt;
    logic [WORDLENGTH-1:0] instruction_out;
    logic [WORDLENGTH-1:0] PC_plus4_out;
    logic                  valid_out;
    logic                  stall;
    logic                  bubble;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    // Surrounding pipeline: drives fetch/redirect/ID-EX state, consumes IF/ID outputs.
    modport master (
        output instruction_in,
        output PC_plus4_in,
        output PC_src,
        output idex_mem_read,
        output idex_rt,
        input  instruction_out,
        input  PC_plus4_out,
        input  valid_out,
        input  stall,
        input  bubble,
        input  stall_count,
        input  flush_count
    );

    // The IF/ID register itself.
    modport slave (
        input  instruction_in,
        input  PC_plus4_in,
        input  PC_src,
        input  idex_mem_read,
        input  idex_rt,
        output instruction_out,
        output PC_plus4_out,
        output valid_out,
        output stall,
        output bubble,
        output stall_count,
        output flush_count
    );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register with load-use hazard detection, redirect flush,
// and saturating stall/flush event counters for debug.
`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif

module if_id_register #(
    parameter int WORDLENGTH = `WORDLENGTH,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    if_id_register_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [WORDLENGTH-1:0] instruction_reg, instruction_next;
    logic [WORDLENGTH-1:0] pc_plus4_reg, pc_plus4_next;
    logic                  valid_reg, valid_next;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       hz;
    logic       flush;
    logic       stall;
    logic       bubble;
    logic [1:0] count_event;

    assign op = instruction_reg[31:26];
    assign rs = instruction_reg[25:21];
    assign rt = instruction_reg[20:16];

    // Hazard logic looks only at registered IF/ID state and ID/EX inputs,
    // never at instruction_in, so there is no fetch-to-stall path.
    always_comb begin
        uses_rs = (op != OP_J) && (op != OP_JAL);
        uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) ||
                  (op == OP_BNE)   || (op == OP_SW);
        hz      = valid_reg && bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
                  ((uses_rs && (rs == bus.idex_rt)) ||
                   (uses_rt && (rt == bus.idex_rt)));
        flush   = (bus.PC_src != 2'b00);
        stall   = hz && !flush;
        bubble  = hz || flush;
    end

    // A redirect outranks a stall: the PC must take the target address.
    always_comb begin
        instruction_next = instruction_reg;
        pc_plus4_next    = pc_plus4_reg;
        valid_next       = valid_reg;
        if (flush) begin
            instruction_next = '0;
            pc_plus4_next    = '0;
            valid_next       = 1'b0;
        end else if (!stall) begin
            instruction_next = bus.instruction_in;
            pc_plus4_next    = bus.PC_plus4_in;
            valid_next       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instruction_reg <= '0;
            pc_plus4_reg    <= '0;
            valid_reg       <= 1'b0;
        end else begin
            instruction_reg <= instruction_next;
            pc_plus4_reg    <= pc_plus4_next;
            valid_reg       <= valid_next;
        end
    end

    // Index 0 counts stall cycles, index 1 counts flush cycles.
    assign count_event = {flush, stall};

    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
        logic [CNT_W-1:0] count_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                count_reg <= '0;
            end else if (count_event[gi] && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.instruction_out = instruction_reg;
    assign bus.PC_plus4_out    = pc_plus4_reg;
    assign bus.valid_out       = valid_reg;
    assign bus.stall           = stall;
    assign bus.bubble          = bubble;
    assign bus.stall_count     = gen_cnt[0].count_reg;
    assign bus.flush_count     = gen_cnt[1].count_reg;
endmodule

// File: doc/if_id_register.md
# if_id_register

Pipeline register and hazard control between the instruction-fetch stage and the decode stage of the 5-stage MIPS pipeline. Each cycle it captures the fetched instruction and PC+4 from IF, detects load-use hazards against the instruction in ID/EX, and flushes wrong-path instructions on a redirect. It drives the IF stage's `stall` input, and drives a `bubble` that zeroes ID/EX control. It also keeps saturating stall and flush event counters for debug.

## Interface
- `WORDLENGTH`, 32: datapath width. Uses the global `` `WORDLENGTH `` define.
- `CNT_W`, 16: width of the event counters.

Ports (clock and reset first):
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `instruction_in` in WORDLENGTH: instruction from IF. Valid in the same cycle as `PC_plus4_in`.
- `PC_plus4_in` in WORDLENGTH: PC+4 from IF.
- `PC_src` in 2: redirect select driven to IF (0 = sequential, 1 = branch, 2 = jump, 3 = reserved, treated as redirect). Any nonzero value is a flush.
- `idex_mem_read` in 1: the instruction in ID/EX is a load.
- `idex_rt` in 5: destination register of that load.
- `instruction_out` out WORDLENGTH: registered instruction to ID.
- `PC_plus4_out` out WORDLENGTH: registered PC+4 to ID.
- `valid_out` out 1: the IF/ID contents are a real instruction.
- `stall` out 1: to IF. Holds the PC and this register. Combinational.
- `bubble` out 1: to ID/EX. Inserts a NOP. Combinational.
- `stall_count` out CNT_W: saturating count of stall cycles.
- `flush_count` out CNT_W: saturating count of flush events.

## Operation
- Decode fields of `instruction_out`:
  - `op` = [31:26], `rs` = [25:21], `rt` = [20:16].
  - uses_rs = `op` is not 0x02 (j) and not 0x03 (jal).
  - uses_rt = `op` is one of 0x00, 0x04, 0x05, 0x2B.
- Hazard `hz` = `valid_out` & `idex_mem_read` & (`idex_rt` ≠ 0) & ((uses_rs & `rs`==`idex_rt`) | (uses_rt & `rt`==`idex_rt`)).
- `flush` = (`PC_src` ≠ 0).
- `stall` = `hz` & ~`flush`.
- `bubble` = `hz` | `flush`.
- Register update, in priority order:
  - `reset`: `instruction_out`=0, `PC_plus4_out`=0, `valid_out`=0, both counters = 0.
  - else `flush`: `instruction_out`=0 (NOP), `PC_plus4_out`=0, `valid_out`=0. The IF/ID instruction is on the wrong path.
  - else `stall`: hold all three registers.
  - else load: `instruction_in`, `PC_plus4_in`, `valid_out`=1.
- Counters:
  - `stall_count` increments on each cycle with `stall`=1.
  - `flush_count` increments on each cycle with `flush`=1.
  - Both saturate at all-ones and never wrap.
- States, implicit in `valid_out` and `hz`:
  - EMPTY: valid=0.
  - RUN: valid=1, no hazard.
  - STALL: valid=1, hazard.
- Transitions:
  - EMPTY→RUN on the first load after reset or flush.
  - RUN→STALL when `hz` rises.
  - STALL→RUN when `idex_mem_read` clears. ID/EX holds a bubble after one stall cycle, so a single load-use stall lasts exactly 1 cycle.
  - Any state→EMPTY on `flush`.

## Timing
- Load-to-output latency: 1 cycle (input at edge N appears after edge N).
- `stall` and `bubble` are combinational from registered IF/ID state plus ID/EX inputs. There is no path from `instruction_in` to `stall`.
- EMPTY (valid=0) never raises `stall`. A NOP in IF/ID never stalls.
- Flush and hazard in the same cycle: the flush wins. `stall`=0, so the PC accepts the target; `bubble`=1; IF/ID is cleared; `stall_count` does not increment.
- Reset asserted mid-stall or mid-flush: outputs are all zero after the edge. `stall`=0 and `bubble`=0 in the following cycle.
- Back-to-back flushes: every cycle stays EMPTY, and `flush_count` increments every cycle.

## Test plan
- Reset, then stream 0x00411820 / PC+4 = 0x8 with no hazards.
  - Expect: one cycle later `instruction_out`=0x00411820, `PC_plus4_out`=0x8, `valid_out`=1, `stall`=0.
- IF/ID holds add $3,$2,$1 (0x00411820) while ID/EX is lw to $2 (`idex_mem_read`=1, `idex_rt`=2).
  - Expect: `stall`=1 and `bubble`=1 for exactly one cycle, IF/ID held, `stall_count`=1.
  - Then `idex_mem_read`=0: the next instruction loads.
- Same hazard with `idex_rt`=0, or with IF/ID holding j 0x08000010 against `idex_rt`=2.
  - Expect: `stall`=0.
- `PC_src`=1 for one cycle while IF/ID holds 0x00411820.
  - Expect: next cycle `instruction_out`=0, `valid_out`=0, `flush_count`=1.
  - Then the target instruction loads on the following edge.
- Load-use hazard and `PC_src`=2 in the same cycle.
  - Expect: `stall`=0, `bubble`=1, IF/ID cleared, `stall_count` unchanged, `flush_count`+1.
- Preload `stall_count` to 0xFFFE and hold the hazard for 3 cycles.
  - Expect: the count saturates at 0xFFFF.
  - Then assert `reset` mid-stall: all outputs are 0 after one edge.
